// File: rtl/if_prefetch_queue_pkg.sv
// Shared types and widths for the instruction prefetch queue.
// Queue entries pack {PC, IR} as one 64-bit word with PC in the upper half.
package if_prefetch_queue_pkg;

  localparam int unsigned IFQ_ENTRY_W = 64;
  localparam int unsigned IFQ_PC_LSB  = 32;
  localparam int unsigned IFQ_IR_LSB  = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } ifq_entry_t;

  // Width of a counter that must hold the value n itself.
  function automatic int unsigned ifq_cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  function automatic logic [31:0] ifq_bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/if_prefetch_queue_fifo.sv
// Synchronous FIFO with flush; head word read combinationally, a push shows at the head next cycle.
// No internal backpressure: the owner guarantees no push when full and no pop when empty.
module if_prefetch_queue_fifo
  import if_prefetch_queue_pkg::*;
#(
  parameter  int unsigned W     = 32,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = ifq_cnt_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [W-1:0]     push_dat_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] count_o,
  output logic [W-1:0]     head_dat_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  always_comb begin
    do_push  = push_i && !flush_i;
    do_pop   = pop_i && !flush_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q <= '{default: '0};
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  assign count_o    = cnt_q;
  assign head_dat_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_prefetch_queue.sv
// RV32I fetch front end: sequential prefetch into a DEPTH-entry {PC,IR} queue; IFQ_BSWAP_EN byte-reverses fetched words.
// Response in cycle N is visible to decode in N+1; requests stall on credit (queue + in-flight) and on D_READY backpressure.
module if_prefetch_queue
  import if_prefetch_queue_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_OUTS = 2
) (
  input  logic        CLK,
  input  logic        RSTN,
  output logic        IM_REQ,
  output logic [31:0] IM_ADDR,
  input  logic        IM_GNT,
  input  logic        IM_RVALID,
  input  logic [31:0] IM_RDATA,
  output logic        D_VALID,
  input  logic        D_READY,
  output logic [31:0] D_PC,
  output logic [31:0] D_IR,
  input  logic        REDIR_VALID,
  input  logic [31:0] REDIR_PC
);

  localparam int unsigned CNT_W  = ifq_cnt_w(DEPTH);
  localparam int unsigned OUTS_W = ifq_cnt_w(MAX_OUTS);
  localparam int unsigned OCC_W  = 8;

  logic [31:0]       fpc_q, fpc_d;
  logic [OUTS_W-1:0] outs_q, outs_d;
  logic [OUTS_W-1:0] drop_q, drop_d;

  logic [CNT_W-1:0]  q_cnt;
  ifq_entry_t        q_head, q_push_dat;
  logic              q_push, q_pop;
  logic [31:0]       pc_head;
  logic [OUTS_W-1:0] pc_cnt;

  logic [OCC_W-1:0]  occ;
  logic              req, fire, rsp_ok, rsp_keep;
  logic [31:0]       rdata_st;

`ifdef IFQ_BSWAP_EN
  assign rdata_st = ifq_bswap32(IM_RDATA);
`else
  assign rdata_st = IM_RDATA;
`endif

  // Slots already promised: buffered entries plus in-flight responses that will be kept.
  assign occ = OCC_W'(q_cnt) + OCC_W'(outs_q) - OCC_W'(drop_q);

  always_comb begin
    req        = RSTN && !REDIR_VALID && (outs_q < OUTS_W'(MAX_OUTS)) && (occ < OCC_W'(DEPTH));
    fire       = req && IM_GNT;
    rsp_ok     = IM_RVALID && (outs_q != '0);
    rsp_keep   = rsp_ok && (drop_q == '0) && !REDIR_VALID;
    q_push     = rsp_keep;
    q_pop      = (q_cnt != '0) && D_READY && !REDIR_VALID;
    q_push_dat = '{pc: pc_head, ir: rdata_st};
  end

  always_comb begin
    fpc_d  = fpc_q;
    outs_d = outs_q + OUTS_W'(fire) - OUTS_W'(rsp_ok);
    drop_d = drop_q;
    if (REDIR_VALID) begin
      fpc_d  = REDIR_PC & ~32'h3;
      drop_d = outs_q - OUTS_W'(rsp_ok);
    end else begin
      if (fire) fpc_d = fpc_q + 32'd4;
      if (rsp_ok && (drop_q != '0)) drop_d = drop_q - OUTS_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      fpc_q  <= RESET_PC & ~32'h3;
      outs_q <= '0;
      drop_q <= '0;
    end else begin
      fpc_q  <= fpc_d;
      outs_q <= outs_d;
      drop_q <= drop_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RSTN) begin
      assert (!(IM_RVALID && (outs_q == '0)))
        else $error("if_prefetch_queue: IM_RVALID with no request in flight");
      assert (pc_cnt == outs_q)
        else $error("if_prefetch_queue: request-PC FIFO out of step with in-flight count");
    end
  end

  // Not flushed on redirect: stale responses still pop their PC so the FIFO stays aligned.
  if_prefetch_queue_fifo #(
    .W     (32),
    .DEPTH (MAX_OUTS)
  ) u_pc_fifo (
    .clk_i      (CLK),
    .rst_ni     (RSTN),
    .push_i     (fire),
    .push_dat_i (fpc_q),
    .pop_i      (rsp_ok),
    .flush_i    (1'b0),
    .count_o    (pc_cnt),
    .head_dat_o (pc_head)
  );

  if_prefetch_queue_fifo #(
    .W     (IFQ_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_entry_fifo (
    .clk_i      (CLK),
    .rst_ni     (RSTN),
    .push_i     (q_push),
    .push_dat_i (q_push_dat),
    .pop_i      (q_pop),
    .flush_i    (REDIR_VALID),
    .count_o    (q_cnt),
    .head_dat_o (q_head)
  );

  assign IM_REQ  = req;
  assign IM_ADDR = fpc_q;
  assign D_VALID = RSTN && (q_cnt != '0);
  assign D_PC    = RSTN ? q_head.pc : 32'h0;
  assign D_IR    = RSTN ? q_head.ir : 32'h0;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: in-order memory model with random grant/latency, and a
// stream model where decode must see consecutive PCs from the last redirect target.
module tb_if_prefetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;
  localparam int          MAX_OUTS = 2;

  logic        CLK = 1'b0;
  logic        RSTN, IM_REQ, IM_GNT, IM_RVALID, D_VALID, D_READY, REDIR_VALID;
  logic [31:0] IM_ADDR, IM_RDATA, D_PC, D_IR, REDIR_PC;

  always #5 CLK = ~CLK;

  if_prefetch_queue #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH),
    .MAX_OUTS (MAX_OUTS)
  ) dut (
    .CLK         (CLK),
    .RSTN        (RSTN),
    .IM_REQ      (IM_REQ),
    .IM_ADDR     (IM_ADDR),
    .IM_GNT      (IM_GNT),
    .IM_RVALID   (IM_RVALID),
    .IM_RDATA    (IM_RDATA),
    .D_VALID     (D_VALID),
    .D_READY     (D_READY),
    .D_PC        (D_PC),
    .D_IR        (D_IR),
    .REDIR_VALID (REDIR_VALID),
    .REDIR_PC    (REDIR_PC)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  int          n_vec = 0, n_bad = 0;
  int          cyc, last_due, n_grant, n_hs, first_hs_cyc;
  int unsigned gnt_pct, rdy_pct, lat_min, lat_max;
  logic [31:0] exp_fetch, exp_dec, hold_addr, last_grant_addr, first_grant_addr;
  logic [31:0] first_hs_pc, first_hs_ir;
  bit          hold_vld, saw_req, saw_dvalid;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0300) return 32'h1305_0000;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] dec_word(input logic [31:0] w);
`ifdef IFQ_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic clr_stats();
    n_grant = 0;
    n_hs = 0;
    first_hs_cyc = -1;
  endtask

  task automatic apply_reset();
    RSTN = 1'b0; IM_GNT = 1'b0; IM_RVALID = 1'b0; IM_RDATA = 32'h0;
    D_READY = 1'b0; REDIR_VALID = 1'b0; REDIR_PC = 32'h0;
    repeat (2) @(posedge CLK);
    #1;
    pend.delete();
    cyc = 0; last_due = 0; hold_vld = 0;
    exp_fetch = RESET_PC; exp_dec = RESET_PC;
    clr_stats();
    RSTN = 1'b1;
  endtask

  // One clock: drive inputs, check at negedge, update the models, advance.
  task automatic tick(input bit redir, input logic [31:0] rpc);
    bit rv;
    int due;
    cyc++;
    rv = 1'b0;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      rv = 1'b1;
      IM_RDATA = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      IM_RDATA = $urandom;
    end
    IM_RVALID   = rv;
    IM_GNT      = ($urandom_range(0, 99) < gnt_pct);
    D_READY     = ($urandom_range(0, 99) < rdy_pct);
    REDIR_VALID = redir;
    REDIR_PC    = rpc;
    @(negedge CLK);
    n_vec++;
    if ($isunknown({IM_REQ, D_VALID})) begin
      n_bad++; $display("FAIL known_ctrl: got req=%b dvalid=%b, need 0/1", IM_REQ, D_VALID);
    end
    if (redir) begin
      n_vec++;
      if (IM_REQ !== 1'b0) begin n_bad++; $display("FAIL redir_no_req: IM_REQ=%b need 0", IM_REQ); end
    end else if (hold_vld) begin
      n_vec++;
      if (IM_REQ !== 1'b1 || IM_ADDR !== hold_addr) begin
        n_bad++; $display("FAIL req_hold: req=%b addr=%h need 1/%h", IM_REQ, IM_ADDR, hold_addr);
      end
    end
    if (IM_REQ === 1'b1) begin
      n_vec++;
      if (IM_ADDR !== exp_fetch) begin
        n_bad++; $display("FAIL fetch_addr: got %h need %h (cyc %0d)", IM_ADDR, exp_fetch, cyc);
      end
      n_vec++;
      if (pend.size() + int'(rv) >= MAX_OUTS) begin
        n_bad++; $display("FAIL outs_limit: requesting with %0d in flight, max %0d", pend.size() + int'(rv), MAX_OUTS);
      end
    end
    if (D_VALID === 1'b1 && D_READY && !redir) begin
      n_vec++;
      if (D_PC !== exp_dec) begin
        n_bad++; $display("FAIL dec_pc: got %h need %h (cyc %0d)", D_PC, exp_dec, cyc);
      end
      n_vec++;
      if (D_IR !== dec_word(mem_word(exp_dec))) begin
        n_bad++; $display("FAIL dec_ir: got %h need %h", D_IR, dec_word(mem_word(exp_dec)));
      end
      if (first_hs_cyc < 0) begin
        first_hs_cyc = cyc; first_hs_pc = D_PC; first_hs_ir = D_IR;
      end
      exp_dec += 32'd4;
      n_hs++;
    end
    saw_req    = (IM_REQ === 1'b1);
    saw_dvalid = (D_VALID === 1'b1);
    hold_vld   = 1'b0;
    if (saw_req && IM_GNT) begin
      due = cyc + int'($urandom_range(lat_min, lat_max));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{addr: IM_ADDR, due: due});
      if (n_grant == 0) first_grant_addr = IM_ADDR;
      last_grant_addr = IM_ADDR;
      exp_fetch += 32'd4;
      n_grant++;
    end else if (saw_req) begin
      hold_vld  = 1'b1;
      hold_addr = IM_ADDR;
    end
    if (redir) begin
      exp_fetch = rpc & ~32'h3;
      exp_dec   = rpc & ~32'h3;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic set_knobs(input int unsigned g, input int unsigned r, input int unsigned l0, input int unsigned l1);
    gnt_pct = g; rdy_pct = r; lat_min = l0; lat_max = l1;
  endtask

  // Stop fetching, let everything return: all fetched PCs must have reached decode.
  task automatic drain(input string tag);
    gnt_pct = 0; rdy_pct = 100;
    for (int i = 0; i < 100 && pend.size() != 0; i++) tick(1'b0, 32'h0);
    repeat (DEPTH + 2) tick(1'b0, 32'h0);
    n_vec++;
    if (exp_dec !== exp_fetch) begin
      n_bad++; $display("FAIL %s_drain: decoded up to %h, fetched up to %h", tag, exp_dec, exp_fetch);
    end
    n_vec++;
    if (saw_dvalid !== 1'b0) begin n_bad++; $display("FAIL %s_empty: D_VALID=%b need 0", tag, saw_dvalid); end
  endtask

  task automatic test_reset();
    RSTN = 1'b0; IM_RVALID = 1'b0; IM_RDATA = 32'h0;
    for (int i = 0; i < 4; i++) begin
      IM_GNT = 1'($urandom); D_READY = 1'($urandom);
      REDIR_VALID = 1'($urandom); REDIR_PC = $urandom;
      @(negedge CLK);
      n_vec++; if (IM_REQ !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b need 0", IM_REQ); end
      n_vec++; if (D_VALID !== 1'b0) begin n_bad++; $display("FAIL rst_dvalid: got %b need 0", D_VALID); end
      n_vec++; if (D_PC !== 32'h0) begin n_bad++; $display("FAIL rst_dpc: got %h need 0", D_PC); end
      n_vec++; if (D_IR !== 32'h0) begin n_bad++; $display("FAIL rst_dir: got %h need 0", D_IR); end
      @(posedge CLK);
      #1;
    end
    apply_reset();
    set_knobs(0, 100, 1, 1);
    tick(1'b0, 32'h0);
    n_vec++; if (saw_dvalid !== 1'b0) begin n_bad++; $display("FAIL post_rst_dvalid: got 1 need 0"); end
    n_vec++; if (saw_req !== 1'b1) begin n_bad++; $display("FAIL post_rst_req: got 0 need 1"); end
  endtask

  task automatic test_stream();
    apply_reset();
    set_knobs(100, 100, 1, 1);
    repeat (20) tick(1'b0, 32'h0);
    n_vec++; if (first_hs_cyc != 3) begin n_bad++; $display("FAIL stream_latency: first decode cyc %0d need 3", first_hs_cyc); end
    n_vec++; if (n_grant != 20) begin n_bad++; $display("FAIL stream_grants: got %0d need 20", n_grant); end
    n_vec++; if (n_hs != 18) begin n_bad++; $display("FAIL stream_decodes: got %0d need 18", n_hs); end
    drain("stream");
  endtask

  task automatic test_full();
    apply_reset();
    set_knobs(100, 0, 1, 1);
    repeat (12) tick(1'b0, 32'h0);
    n_vec++; if (n_grant != DEPTH) begin n_bad++; $display("FAIL full_grants: got %0d need %0d", n_grant, DEPTH); end
    n_vec++; if (saw_req !== 1'b0) begin n_bad++; $display("FAIL full_req: IM_REQ=%b need 0", saw_req); end
    n_vec++; if (saw_dvalid !== 1'b1) begin n_bad++; $display("FAIL full_dvalid: got %b need 1", saw_dvalid); end
    clr_stats();
    rdy_pct = 100;
    repeat (10) tick(1'b0, 32'h0);
    n_vec++; if (first_grant_addr !== 32'h10) begin n_bad++; $display("FAIL full_resume: got %h need 00000010", first_grant_addr); end
    n_vec++; if (n_hs != 10) begin n_bad++; $display("FAIL full_decodes: got %0d need 10", n_hs); end
    drain("full");
  endtask

  task automatic test_gnt_stall();
    apply_reset();
    set_knobs(100, 100, 1, 1);
    repeat (3) tick(1'b0, 32'h0);
    gnt_pct = 0;
    repeat (5) tick(1'b0, 32'h0);
    n_vec++; if (hold_addr !== 32'hC) begin n_bad++; $display("FAIL stall_addr: got %h need 0000000c", hold_addr); end
    clr_stats();
    gnt_pct = 100;
    repeat (5) tick(1'b0, 32'h0);
    n_vec++; if (last_grant_addr !== 32'h1C) begin n_bad++; $display("FAIL stall_resume: got %h need 0000001c", last_grant_addr); end
    drain("stall");
  endtask

  task automatic test_redirect();
    apply_reset();
    set_knobs(100, 100, 3, 3);
    repeat (2) tick(1'b0, 32'h0);
    tick(1'b1, 32'h200);
    clr_stats();
    repeat (12) tick(1'b0, 32'h0);
    n_vec++; if (first_hs_pc !== 32'h200) begin n_bad++; $display("FAIL redir_first: got %h need 00000200", first_hs_pc); end
    n_vec++; if (n_hs < 2) begin n_bad++; $display("FAIL redir_count: got %0d decodes need >=2", n_hs); end
    drain("redir");
  endtask

  task automatic test_redir_collide();
    apply_reset();
    set_knobs(100, 100, 1, 1);
    repeat (5) tick(1'b0, 32'h0);
    tick(1'b1, 32'h103);
    n_vec++; if (saw_dvalid !== 1'b1) begin n_bad++; $display("FAIL collide_dvalid: got %b need 1", saw_dvalid); end
    clr_stats();
    tick(1'b0, 32'h0);
    n_vec++; if (n_grant != 1 || first_grant_addr !== 32'h100) begin
      n_bad++; $display("FAIL collide_fetch: grants %0d addr %h need 1/00000100", n_grant, first_grant_addr);
    end
    repeat (6) tick(1'b0, 32'h0);
    n_vec++; if (first_hs_pc !== 32'h100) begin n_bad++; $display("FAIL collide_first: got %h need 00000100", first_hs_pc); end
    drain("collide");
  endtask

  task automatic test_back_to_back();
    apply_reset();
    set_knobs(100, 100, 2, 4);
    repeat (4) tick(1'b0, 32'h0);
    tick(1'b1, 32'h400);
    tick(1'b1, 32'h800);
    clr_stats();
    repeat (14) tick(1'b0, 32'h0);
    n_vec++; if (first_hs_pc !== 32'h800) begin n_bad++; $display("FAIL b2b_first: got %h need 00000800", first_hs_pc); end
    drain("b2b");
  endtask

  task automatic test_wrap();
    apply_reset();
    set_knobs(100, 100, 1, 2);
    tick(1'b1, 32'hFFFF_FFF9);
    clr_stats();
    repeat (10) tick(1'b0, 32'h0);
    n_vec++; if (first_hs_pc !== 32'hFFFF_FFF8) begin n_bad++; $display("FAIL wrap_first: got %h need fffffff8", first_hs_pc); end
    n_vec++; if (n_hs < 3) begin n_bad++; $display("FAIL wrap_count: got %0d decodes need >=3", n_hs); end
    drain("wrap");
  endtask

  task automatic test_bswap();
    logic [31:0] want;
`ifdef IFQ_BSWAP_EN
    want = 32'h0000_0513;
`else
    want = 32'h1305_0000;
`endif
    apply_reset();
    set_knobs(100, 100, 1, 1);
    tick(1'b1, 32'h300);
    clr_stats();
    repeat (6) tick(1'b0, 32'h0);
    n_vec++; if (first_hs_ir !== want) begin n_bad++; $display("FAIL bswap_ir: got %h need %h", first_hs_ir, want); end
    drain("bswap");
  endtask

  task automatic test_random();
    logic [31:0] rpc;
    bit          rd;
    apply_reset();
    for (int blk = 0; blk < 30; blk++) begin
      set_knobs($urandom_range(30, 100), $urandom_range(20, 100), 1, $urandom_range(1, 6));
      for (int i = 0; i < 100; i++) begin
        rd  = ($urandom_range(0, 99) < 3);
        rpc = $urandom_range(0, 32'hFFFF);
        if ($urandom_range(0, 9) == 0) rpc = 32'hFFFF_FFF0 | $urandom_range(0, 15);
        tick(rd, rpc);
      end
    end
    drain("random");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_gnt_stall();
    test_redirect();
    test_redir_collide();
    test_back_to_back();
    test_wrap();
    test_bswap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
